// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// Holds the fetch FSM encoding and the IF/ID bundle layout.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_ifid_reg.sv
// IF/ID pipeline register.
// Flush beats stall, stall beats load; idle cycles become bubbles.
module mips_ifid_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output if_id_t          ifid_o
);

  if_id_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    priority case (1'b1)
      flush_i: begin
        ifid_d.valid = 1'b0;
        ifid_d.instr = NOP_INSTR;
      end
      stall_i: begin
        ifid_d = ifid_q;
      end
      load_i: begin
        ifid_d.instr    = instr_i;
        ifid_d.pc_plus4 = pc_plus4_i;
        ifid_d.valid    = 1'b1;
      end
      default: begin
        ifid_d.valid = 1'b0;
        ifid_d.instr = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc_plus4 <= '0;
      ifid_q.valid    <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem read in flight,
// and feeds the IF/ID register under stall and redirect control.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic            ifid_valid
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic            squash_q;
  logic [XLEN-1:0] hold_q;

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_inc;
  logic            req;
  logic [XLEN-1:0] addr;
  logic            load;
  logic [XLEN-1:0] load_instr;
  if_id_t          ifid;

  assign tgt    = word_align(redirect_target);
  assign pc_inc = pc_q + 32'd4;

  // A fresh response with no stall chains straight into the next read.
  always_comb begin
    req        = 1'b0;
    addr       = pc_q;
    load       = 1'b0;
    load_instr = imem_rdata;
    unique case (state_q)
      FETCH: begin
        req = !redirect;
      end
      WAIT: begin
        if (imem_valid && !squash_q && !redirect && !stall) begin
          req  = 1'b1;
          addr = pc_inc;
          load = 1'b1;
        end
      end
      HOLD: begin
        if (!redirect && !stall) begin
          load       = 1'b1;
          load_instr = hold_q;
        end
      end
      default: begin
        req = 1'b0;
      end
    endcase
  end

  assign imem_req  = req && reset;
  assign imem_addr = addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      hold_q   <= NOP_INSTR;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (redirect) pc_q <= tgt;
          else state_q <= WAIT;
        end
        WAIT: begin
          if (imem_valid) begin
            if (squash_q || redirect) begin
              squash_q <= 1'b0;
              state_q  <= FETCH;
              if (redirect) pc_q <= tgt;
            end else if (!stall) begin
              pc_q <= pc_inc;
            end else begin
              hold_q  <= imem_rdata;
              state_q <= HOLD;
            end
          end else if (redirect) begin
            // The in-flight read is stale; drop it when it lands.
            pc_q     <= tgt;
            squash_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q    <= tgt;
            state_q <= FETCH;
          end else if (!stall) begin
            pc_q    <= pc_inc;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  mips_ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (redirect),
    .stall_i    (stall),
    .load_i     (load),
    .instr_i    (load_instr),
    .pc_plus4_i (pc_inc),
    .ifid_o     (ifid)
  );

  assign ifid_instr    = ifid.instr;
  assign ifid_pc_plus4 = ifid.pc_plus4;
  assign ifid_valid    = ifid.valid;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios plus a random run
// against an instruction-stream reference model.
module tb_mips_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  int n_chk = 0;
  int n_pass = 0;

  // memory model state
  int          lat = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  bit          overlap = 0;
  logic        req_s;
  logic [31:0] addr_s;

  mips_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h2009_0003;
      32'h8:   return 32'h0109_5020;
      default: return a ^ {a[15:0], a[31:16]} ^ 32'h3C01_8000;
    endcase
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    bit v;
    v = pend && (cnt == 0);
    imem_valid = v;
    imem_rdata = v ? memf(paddr) : $urandom;
    #1;
    req_s = imem_req;
    addr_s = imem_addr;
    overlap = 0;
    if (v) pend = 0;
    else if (pend) cnt--;
    if (imem_req) begin
      overlap = pend;
      pend = 1;
      cnt = lat - 1;
      paddr = imem_addr;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    imem_valid = 1'b0;
    pend = 0;
    cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if ({imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid}
        !== {1'b0, RST_PC, NOP, 32'h0, 1'b0})
      $display("FAIL reset_async: got req=%b addr=%h ifid=%h/%h/%b",
               imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
    else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({imem_req, imem_addr, ifid_valid} !== {1'b0, RST_PC, 1'b0})
      $display("FAIL reset_held: got req=%b addr=%h valid=%b want 0/%h/0",
               imem_req, imem_addr, ifid_valid, RST_PC);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stream();
    apply_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if ({req_s, addr_s} !== {1'b1, 32'(4 * i)})
        $display("FAIL stream_addr[%0d]: got %b/%h want 1/%h",
                 i, req_s, addr_s, 32'(4 * i));
      else n_pass++;
      n_chk++;
      if (i == 0) begin
        if (ifid_valid !== 1'b0)
          $display("FAIL stream_first_bubble: got %b want 0", ifid_valid);
        else n_pass++;
      end else if ({ifid_valid, ifid_pc_plus4, ifid_instr}
                   !== {1'b1, 32'(4 * i), memf(32'(4 * (i - 1)))}) begin
        $display("FAIL stream_ifid[%0d]: got %b/%h/%h want 1/%h/%h",
                 i, ifid_valid, ifid_pc_plus4, ifid_instr,
                 32'(4 * i), memf(32'(4 * (i - 1))));
      end else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [64:0] held;
    apply_reset();
    lat = 1;
    repeat (4) tick();
    held = {ifid_valid, ifid_pc_plus4, ifid_instr};
    n_chk++;
    if (held !== {1'b1, 32'd12, memf(32'd8)})
      $display("FAIL stall_pre: got %h want %h",
               held, {1'b1, 32'd12, memf(32'd8)});
    else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({req_s, ifid_valid, ifid_pc_plus4, ifid_instr} !== {1'b0, held})
        $display("FAIL stall_hold[%0d]: got req=%b ifid=%h want 0/%h",
                 i, req_s, {ifid_valid, ifid_pc_plus4, ifid_instr}, held);
      else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4, ifid_instr}
        !== {1'b1, 32'd16, memf(32'd12)})
      $display("FAIL stall_release: got %b/%h/%h want 1/10/%h",
               ifid_valid, ifid_pc_plus4, ifid_instr, memf(32'd12));
    else n_pass++;
    tick();
    n_chk++;
    if ({req_s, addr_s} !== {1'b1, 32'd16})
      $display("FAIL stall_next_req: got %b/%h want 1/10", req_s, addr_s);
    else n_pass++;
    tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4} !== {1'b1, 32'd20})
      $display("FAIL stall_resume: got %b/%h want 1/14",
               ifid_valid, ifid_pc_plus4);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    lat = 3;
    tick();
    repeat (2) tick();
    tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4, ifid_instr}
        !== {1'b1, 32'd4, memf(32'd0)})
      $display("FAIL redir_pre: got %b/%h/%h want 1/4/%h",
               ifid_valid, ifid_pc_plus4, ifid_instr, memf(32'd0));
    else n_pass++;
    redirect = 1'b1;
    redirect_target = 32'h0000_0043;
    tick();
    redirect = 1'b0;
    n_chk++;
    if ({req_s, ifid_valid, ifid_instr} !== {1'b0, 1'b0, NOP})
      $display("FAIL redir_bubble: got req=%b valid=%b instr=%h",
               req_s, ifid_valid, ifid_instr);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if ({req_s, ifid_valid} !== 2'b00)
      $display("FAIL redir_discard: got req=%b valid=%b want 0/0",
               req_s, ifid_valid);
    else n_pass++;
    tick();
    n_chk++;
    if ({req_s, addr_s} !== {1'b1, 32'h40})
      $display("FAIL redir_target: got %b/%h want 1/40", req_s, addr_s);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4, ifid_instr}
        !== {1'b1, 32'h44, memf(32'h40)})
      $display("FAIL redir_load: got %b/%h/%h want 1/44/%h",
               ifid_valid, ifid_pc_plus4, ifid_instr, memf(32'h40));
    else n_pass++;
  endtask

  task automatic test_flush_prio();
    apply_reset();
    lat = 1;
    repeat (2) tick();
    redirect = 1'b1;
    stall = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    n_chk++;
    if ({req_s, ifid_valid, ifid_instr} !== {1'b0, 1'b0, NOP})
      $display("FAIL flush_vs_stall: got req=%b valid=%b instr=%h",
               req_s, ifid_valid, ifid_instr);
    else n_pass++;
    tick();
    n_chk++;
    if ({req_s, addr_s, ifid_valid} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL flush_refetch: got %b/%h/%b want 1/100/0",
               req_s, addr_s, ifid_valid);
    else n_pass++;
    tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4, ifid_instr}
        !== {1'b1, 32'h104, memf(32'h100)})
      $display("FAIL flush_load: got %b/%h/%h want 1/104/%h",
               ifid_valid, ifid_pc_plus4, ifid_instr, memf(32'h100));
    else n_pass++;
    stall = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    n_chk++;
    if ({ifid_valid, ifid_instr} !== {1'b0, NOP})
      $display("FAIL flush_hold: got %b/%h want 0/%h",
               ifid_valid, ifid_instr, NOP);
    else n_pass++;
    tick();
    n_chk++;
    if ({req_s, addr_s} !== {1'b1, 32'h200})
      $display("FAIL flush_hold_req: got %b/%h want 1/200", req_s, addr_s);
    else n_pass++;
    tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4, ifid_instr}
        !== {1'b1, 32'h204, memf(32'h200)})
      $display("FAIL flush_hold_load: got %b/%h/%h want 1/204/%h",
               ifid_valid, ifid_pc_plus4, ifid_instr, memf(32'h200));
    else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset();
    lat = 1;
    repeat (2) tick();
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    tick();
    n_chk++;
    if ({req_s, addr_s} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_req: got %b/%h want 1/fffffffc", req_s, addr_s);
    else n_pass++;
    tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4, ifid_instr, req_s, addr_s}
        !== {1'b1, 32'h0, memf(32'hFFFF_FFFC), 1'b1, 32'h0})
      $display("FAIL wrap_ifid: got %b/%h/%h req=%b/%h want 1/0/%h 1/0",
               ifid_valid, ifid_pc_plus4, ifid_instr, req_s, addr_s,
               memf(32'hFFFF_FFFC));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lat = 1;
    repeat (3) tick();
    lat = 3;
    tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4} !== {1'b1, 32'd12})
      $display("FAIL rstmid_pre: got %b/%h want 1/c",
               ifid_valid, ifid_pc_plus4);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid}
        !== {1'b0, RST_PC, NOP, 32'h0, 1'b0})
      $display("FAIL rstmid_async: got req=%b addr=%h ifid=%h/%h/%b",
               imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
    else n_pass++;
    pend = 0;
    imem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lat = 1;
    tick();
    n_chk++;
    if ({req_s, addr_s} !== {1'b1, RST_PC})
      $display("FAIL rstmid_restart: got %b/%h want 1/%h",
               req_s, addr_s, RST_PC);
    else n_pass++;
    tick();
    n_chk++;
    if ({ifid_valid, ifid_pc_plus4, ifid_instr}
        !== {1'b1, RST_PC + 32'd4, memf(RST_PC)})
      $display("FAIL rstmid_load: got %b/%h/%h",
               ifid_valid, ifid_pc_plus4, ifid_instr);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [64:0] prev;
    logic [64:0] cur;
    int idle;
    apply_reset();
    exp_pc = RST_PC;
    idle = 0;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      stall = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 6);
      redirect_target = $urandom;
      if ($urandom_range(0, 7) == 0)
        redirect_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      prev = {ifid_valid, ifid_pc_plus4, ifid_instr};
      tick();
      cur = {ifid_valid, ifid_pc_plus4, ifid_instr};
      n_chk++;
      if (overlap || (req_s && addr_s[1:0] != 2'b00)) begin
        $display("FAIL rand_proto[%0d]: overlap=%b addr=%h",
                 i, overlap, addr_s);
      end else if (redirect) begin
        if ({ifid_valid, ifid_instr} !== {1'b0, NOP})
          $display("FAIL rand_flush[%0d]: got %b/%h want 0/%h",
                   i, ifid_valid, ifid_instr, NOP);
        else n_pass++;
        exp_pc = {redirect_target[31:2], 2'b00};
        idle = 0;
      end else if (stall) begin
        if (cur !== prev)
          $display("FAIL rand_stall[%0d]: got %h want %h", i, cur, prev);
        else n_pass++;
      end else if (ifid_valid) begin
        if (cur !== {1'b1, exp_pc + 32'd4, memf(exp_pc)})
          $display("FAIL rand_load[%0d]: got %h want %h",
                   i, cur, {1'b1, exp_pc + 32'd4, memf(exp_pc)});
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else begin
        if (cur !== {1'b0, prev[63:32], NOP})
          $display("FAIL rand_bubble[%0d]: got %h want %h",
                   i, cur, {1'b0, prev[63:32], NOP});
        else n_pass++;
      end
      if (!(ifid_valid && !stall)) idle++;
      if (idle > 200) begin
        n_chk++;
        $display("FAIL rand_progress: no instruction in %0d cycles", idle);
        break;
      end
    end
    stall = 1'b0;
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_flush_prio();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch (IF) stage of the MIPS pipeline, sitting directly upstream of decode inside `MIPS_Pipeline_Top`. It owns the program counter and issues word reads to instruction memory with one request outstanding at a time. It loads the IF/ID pipeline register, honouring stall from the hazard unit and redirect (branch/jump flush) from execute. With 1-cycle memory it sustains one instruction per cycle.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; low 2 bits must be 0.
- `NOP_INSTR`, default 32'h0000_0000: bubble value loaded into `ifid_instr` (sll $0,$0,0).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold IF/ID and PC.
- `redirect`  in  1  taken branch/jump: flush and refetch.
- `redirect_target`  in  32  new PC; bits [1:0] ignored (forced 0).
- `imem_req`  out  1  read request; accepted by memory unconditionally.
- `imem_addr`  out  32  byte address of request, word aligned.
- `imem_valid`  in  1  response strobe, ≥1 cycle after `imem_req`, one per request.
- `imem_rdata`  in  32  instruction, valid with `imem_valid`.
- `ifid_instr`  out  32  IF/ID instruction.
- `ifid_pc_plus4`  out  32  IF/ID PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.

## Operation
- Registers: `pc` (address of the instruction in flight), FSM state, `squash` flag, `hold_instr` buffer, IF/ID triple.
- States:
  - FETCH: `imem_req` = !redirect, `imem_addr` = pc. If redirect: pc ← target, stay in FETCH. Else go to WAIT.
  - WAIT: awaiting a response. On `imem_valid`:
    - squash set or redirect high: discard response, clear squash, go to FETCH. pc ← target if redirect this cycle, else pc already holds the target.
    - stall low: IF/ID ← {imem_rdata, pc+4, 1}, pc ← pc+4, assert `imem_req` at `imem_addr` = pc+4 in the same cycle, stay in WAIT.
    - stall high: hold_instr ← imem_rdata, go to HOLD.
  - WAIT, redirect without `imem_valid`: pc ← target, squash ← 1, stay in WAIT.
  - HOLD: when stall is low, IF/ID ← {hold_instr, pc+4, 1}, pc ← pc+4, go to FETCH. Redirect: drop hold_instr, pc ← target, go to FETCH.
- IF/ID update rules, in priority order:
  - redirect: ifid_valid ← 0 and ifid_instr ← NOP_INSTR. This wins over stall.
  - stall: hold all three fields.
  - otherwise load the new instruction if one is available, else bubble (valid 0, NOP_INSTR, pc_plus4 unchanged).
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Exactly one request is outstanding at any time. A second `imem_req` is never issued before the prior `imem_valid`.

## Timing
- During reset:
  - state = FETCH, pc = RESET_PC, squash = 0.
  - `imem_req` = 0 (gated by reset), `imem_addr` = RESET_PC.
  - ifid_instr = NOP_INSTR, ifid_pc_plus4 = 0, ifid_valid = 0.
- First `imem_req` is asserted in the first cycle after reset deasserts.
- Latency: `imem_valid` at edge N → `ifid_*` valid after edge N (visible in cycle N+1).
- Back-to-back 1-cycle memory: one valid instruction per cycle in steady state.
- Redirect at edge N:
  - IF/ID is a bubble after edge N.
  - Request to the target is issued in cycle N+1 (from FETCH), or after the squashed response returns (from WAIT).
- Reset asserted mid-operation aborts immediately. Any response arriving after reset release, for a request issued before reset, is not supported; the memory is reset in the same domain.

## Structure
- Shared package `mips_pkg`:
  - `fetch_state_t` enum {FETCH, WAIT, HOLD}.
  - `NOP_INSTR` and `RESET_PC` defaults.
  - Word width constant 32.
- One natural sub-module: `mips_ifid_reg`, the IF/ID register with stall/flush/load priority. The FSM and PC stay in `mips_fetch_stage`.

## Test plan
- Reset, 1-cycle memory returning 32'h2008_0005, 32'h2009_0003, …: imem_addr 0, 4, 8 on consecutive cycles; ifid_pc_plus4 = 4, 8, 12; ifid_valid high every cycle.
- Stall held 3 cycles while a response arrives: FSM enters HOLD; IF/ID unchanged; no new `imem_req`. After release, the held instruction loads with the correct pc_plus4.
- Redirect to 32'h0000_0043 while in WAIT with a 3-cycle memory:
  - IF/ID is a bubble next cycle.
  - The late response is discarded.
  - Next `imem_addr` = 32'h0000_0040.
- Redirect and stall together, and redirect coincident with `imem_valid`: flush wins, and the instruction is never loaded.
- Fetch from pc 32'hFFFF_FFFC: ifid_pc_plus4 = 0, and the next `imem_addr` is 0.
- Assert reset mid-WAIT: all outputs return to reset values asynchronously. After release, fetch restarts at RESET_PC.
